// File: rtl/alu_cmd_issuer_if.sv
// Handshake and ALU-side bundle for alu_cmd_issuer: command in, registered ALU
// operands out, ALU result back, response out, plus status.
interface alu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_chain;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_co;
  logic        alu_zero;
  logic        alu_ovf;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_co;
  logic        rsp_zero;
  logic        rsp_ovf;

  logic [7:0]  ovf_cnt;
  logic        busy;

  // Upstream side: issues commands, consumes responses and hosts the ALU.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output alu_res, alu_co, alu_zero, alu_ovf,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_ctr,
    input  rsp_valid, rsp_res, rsp_co, rsp_zero, rsp_ovf,
    input  ovf_cnt, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  alu_res, alu_co, alu_zero, alu_ovf,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_ctr,
    output rsp_valid, rsp_res, rsp_co, rsp_zero, rsp_ovf,
    output ovf_cnt, busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Sequential front end for a combinational 32-bit ALU: registers a command onto
// the ALU inputs, waits SETTLE cycles, then holds the captured result for pickup.
module alu_cmd_issuer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // SETTLE is only meaningful in 1..15, so the countdown fits in four bits.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_ctr_q, alu_ctr_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic        rsp_co_q, rsp_co_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctr_d  = alu_ctr_q;
    rsp_res_d  = rsp_res_q;
    rsp_co_d   = rsp_co_q;
    rsp_zero_d = rsp_zero_q;
    rsp_ovf_d  = rsp_ovf_q;
    acc_d      = acc_q;
    ovf_cnt_d  = ovf_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d   = bus.cmd_chain ? acc_q : bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_ctr_d = bus.cmd_op;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_res_d  = bus.alu_res;
          rsp_co_d   = bus.alu_co;
          rsp_zero_d = bus.alu_zero;
          rsp_ovf_d  = bus.alu_ovf;
          acc_d      = bus.alu_res;
          if (bus.alu_ovf && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // The accept is deliberately deferred to the next cycle in IDLE.
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_ctr_q  <= 3'd0;
      rsp_res_q  <= 32'd0;
      rsp_co_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      acc_q      <= 32'd0;
      ovf_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctr_q  <= alu_ctr_d;
      rsp_res_q  <= rsp_res_d;
      rsp_co_q   <= rsp_co_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_ovf_q  <= rsp_ovf_d;
      acc_q      <= acc_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Handshake outputs are masked while reset is held so nothing upstream can
  // mistake a pre-reset state for a live one.
  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == ST_RESP) && !rst;
  assign bus.busy      = (state_q != ST_IDLE) && !rst;

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_ctr  = alu_ctr_q;
  assign bus.rsp_res  = rsp_res_q;
  assign bus.rsp_co   = rsp_co_q;
  assign bus.rsp_zero = rsp_zero_q;
  assign bus.rsp_ovf  = rsp_ovf_q;
  assign bus.ovf_cnt  = ovf_cnt_q;

endmodule
